sipo_window_ctrl: RTL and testbench

//  Sequencer for the 9x16-bit SIPO window register feeding the VAE conv PE.

---
 rtl/sipo_window_ctrl.sv | 90 +++++++++
 tb/tb_sipo_window_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_window_ctrl.sv
// Sequencer for the 9-word SIPO window register in front of the conv PE.
// Shifts in one accepted word per cycle, loads the window, then holds it under valid/ready.
module sipo_window_ctrl #(
    parameter int N_IN  = 9,
    parameter int WIDTH = 16,
    parameter int N_WIN = 196,
    parameter int WIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_sipo_shift_en,
    output logic [WIDTH-1:0] o_sipo_serial,
    output logic             o_sipo_load,
    output logic             o_window_valid,
    input  logic             i_window_ready,
    output logic             o_window_last,
    output logic [WIN_W-1:0] o_window_idx
);

    localparam int              FW        = $clog2(N_IN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N_IN);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(N_WIN - 1);

    logic [FW-1:0]    r_fill_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_shift_en;
    logic [WIDTH-1:0] r_serial;
    logic             r_load;
    logic             r_window_valid;

    logic w_full;
    logic w_accept;
    logic w_slot_free;
    logic w_consume;
    logic w_load_req;

    // in_ready depends only on state (and reset), never on in_valid.
    assign w_full      = (r_fill_cnt == FILL_FULL);
    assign o_in_ready  = !i_rst && (r_fill_cnt < FILL_FULL);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_consume   = r_window_valid && i_window_ready;
    assign w_slot_free = !r_window_valid || i_window_ready;
    assign w_load_req  = w_full && w_slot_free;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_cnt     <= '0;
            r_win_cnt      <= '0;
            r_shift_en     <= 1'b0;
            r_serial       <= '0;
            r_load         <= 1'b0;
            r_window_valid <= 1'b0;
        end else begin
            r_shift_en <= w_accept;
            if (w_accept) begin
                r_serial <= i_in_data;
            end

            // A full fill never accepts, so load and increment are exclusive.
            if (w_load_req) begin
                r_fill_cnt <= '0;
            end else if (w_accept) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            r_load <= w_load_req;

            if (r_load) begin
                r_window_valid <= 1'b1;
            end else if (w_consume) begin
                r_window_valid <= 1'b0;
            end

            if (w_consume) begin
                r_win_cnt <= (r_win_cnt == WIN_LAST) ? '0 : r_win_cnt + 1'b1;
            end
        end
    end

    assign o_sipo_shift_en = r_shift_en;
    assign o_sipo_serial   = r_serial;
    assign o_sipo_load     = r_load;
    assign o_window_valid  = r_window_valid;
    assign o_window_idx    = r_win_cnt;
    assign o_window_last   = (r_win_cnt == WIN_LAST);

endmodule

// File: tb/tb_sipo_window_ctrl.sv
// Directed bench for sipo_window_ctrl: vector table for single/gapped windows,
// hand sequences for reset, back-pressure, frame wrap and mid-window reset.
module tb_sipo_window_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_in_data;
    logic        o_sipo_shift_en;
    logic [15:0] o_sipo_serial;
    logic        o_sipo_load;
    logic        o_window_valid;
    logic        i_window_ready;
    logic        o_window_last;
    logic [7:0]  o_window_idx;

    sipo_window_ctrl #(.N_IN(9), .WIDTH(16), .N_WIN(196), .WIN_W(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_in_data      (i_in_data),
        .o_sipo_shift_en(o_sipo_shift_en),
        .o_sipo_serial  (o_sipo_serial),
        .o_sipo_load    (o_sipo_load),
        .o_window_valid (o_window_valid),
        .i_window_ready (i_window_ready),
        .o_window_last  (o_window_last),
        .o_window_idx   (o_window_idx)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        wrdy;
        logic        e_rdy;
        logic        e_shift;
        logic [15:0] e_ser;
        logic        e_load;
        logic        e_valid;
        logic [7:0]  e_idx;
        logic        chk_win;
        logic [15:0] win_base;
    } vec_t;

    vec_t tbl[$];

    // SIPO register model: m_sreg[8] newest, m_out[0] oldest word of the window.
    logic [15:0] m_sreg[9];
    logic [15:0] m_out[9];

    always @(negedge i_clk) begin
        if (o_sipo_load === 1'b1) m_out = m_sreg;
        if (o_sipo_shift_en === 1'b1) begin
            for (int i = 0; i < 8; i++) m_sreg[i] = m_sreg[i+1];
            m_sreg[8] = o_sipo_serial;
        end
        if (started) begin
            n_cmp++;
            if (o_sipo_shift_en === 1'b1 && o_sipo_load === 1'b1) begin
                n_bad++;
                $display("FAIL shift_load_overlap: shift_en=%0b load=%0b required not both 1 at %0t",
                         o_sipo_shift_en, o_sipo_load, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input logic [15:0] base);
        for (int i = 0; i < 9; i++) chk(name, 32'(m_out[i]), 32'(base + 16'(i)));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_in_valid = 1'b0;
        i_window_ready = 1'b0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic add_vec(input logic vld, input logic [15:0] dat, input logic wrdy,
                           input logic e_rdy, input logic e_shift, input logic [15:0] e_ser,
                           input logic e_load, input logic e_valid, input logic [7:0] e_idx,
                           input logic chk_w, input logic [15:0] base);
        vec_t v;
        v.vld = vld; v.dat = dat; v.wrdy = wrdy; v.e_rdy = e_rdy; v.e_shift = e_shift;
        v.e_ser = e_ser; v.e_load = e_load; v.e_valid = e_valid; v.e_idx = e_idx;
        v.chk_win = chk_w; v.win_base = base;
        tbl.push_back(v);
    endtask

    // Feed words base..base+n-1, holding each until accepted; returns count accepted.
    task automatic feed(input logic [15:0] base, input int n, output int acc);
        int tries;
        acc = 0;
        tries = 0;
        while (acc < n && tries < 4 * n + 20) begin
            i_in_valid = 1'b1;
            i_in_data  = base + 16'(acc);
            #1;
            if (o_in_ready) acc++;
            tick();
            tries++;
        end
        i_in_valid = 1'b0;
    endtask

    initial begin
        int n_acc;
        int consumes;
        int cyc;
        int first_c;
        int last_c;
        logic [15:0] w;

        // Single window, words 1..9 back-to-back, window_ready held high.
        for (int k = 0; k < 9; k++)
            add_vec(1, 16'(k + 1), 1, 1, 1, 16'(k + 1), 0, 0, 8'd0, 0, 16'h0);
        add_vec(0, 16'hDEAD, 1, 0, 0, 16'd9, 1, 0, 8'd0, 0, 16'h0);
        add_vec(0, 16'hDEAD, 1, 1, 0, 16'd9, 0, 1, 8'd0, 1, 16'd1);
        add_vec(0, 16'hDEAD, 1, 1, 0, 16'd9, 0, 0, 8'd1, 0, 16'h0);
        // Gapped input: valid on even beats only, garbage data on idle beats.
        for (int j = 0; j < 18; j++) begin
            logic ev;
            ev = (j % 2 == 0);
            add_vec(ev, ev ? 16'(16'h0100 + j / 2 + 1) : 16'hDEAD, 1,
                    (j <= 16), ev, 16'(16'h0100 + j / 2 + 1), (j == 17), 0, 8'd1, 0, 16'h0);
        end
        add_vec(0, 16'hDEAD, 1, 1, 0, 16'h0109, 0, 1, 8'd1, 1, 16'h0101);
        add_vec(0, 16'hDEAD, 1, 1, 0, 16'h0109, 0, 0, 8'd2, 0, 16'h0);

        for (int i = 0; i < 9; i++) begin
            m_sreg[i] = 16'h0;
            m_out[i]  = 16'h0;
        end

        // Reset held two cycles with in_valid asserted.
        i_rst = 1'b1;
        i_in_valid = 1'b1;
        i_in_data = 16'h5555;
        i_window_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_in_ready", 32'(o_in_ready), 0);
            chk("rst_shift", 32'(o_sipo_shift_en), 0);
            chk("rst_serial", 32'(o_sipo_serial), 0);
            chk("rst_load", 32'(o_sipo_load), 0);
            chk("rst_valid", 32'(o_window_valid), 0);
            chk("rst_last", 32'(o_window_last), 0);
            chk("rst_idx", 32'(o_window_idx), 0);
        end
        i_rst = 1'b0;
        i_in_valid = 1'b0;
        started = 1'b1;

        foreach (tbl[n]) begin
            i_in_valid = tbl[n].vld;
            i_in_data = tbl[n].dat;
            i_window_ready = tbl[n].wrdy;
            #1;
            chk($sformatf("v%0d_in_ready", n), 32'(o_in_ready), 32'(tbl[n].e_rdy));
            tick();
            chk($sformatf("v%0d_shift", n), 32'(o_sipo_shift_en), 32'(tbl[n].e_shift));
            chk($sformatf("v%0d_serial", n), 32'(o_sipo_serial), 32'(tbl[n].e_ser));
            chk($sformatf("v%0d_load", n), 32'(o_sipo_load), 32'(tbl[n].e_load));
            chk($sformatf("v%0d_valid", n), 32'(o_window_valid), 32'(tbl[n].e_valid));
            chk($sformatf("v%0d_idx", n), 32'(o_window_idx), 32'(tbl[n].e_idx));
            chk($sformatf("v%0d_last", n), 32'(o_window_last), 0);
            if (tbl[n].chk_win) chk_win($sformatf("v%0d_window", n), tbl[n].win_base);
        end
        i_in_valid = 1'b0;
        i_window_ready = 1'b0;

        // Back-pressure: 30+ offered words with window_ready low, only two windows' worth fit.
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            i_in_valid = 1'b1;
            i_in_data = 16'(n_acc + 1);
            #1;
            if (o_in_ready) n_acc++;
            tick();
        end
        i_in_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(n_acc), 18);
        chk("bp_in_ready", 32'(o_in_ready), 0);
        chk("bp_valid", 32'(o_window_valid), 1);
        chk("bp_idx", 32'(o_window_idx), 0);
        chk_win("bp_window0", 16'd1);
        i_window_ready = 1'b1;
        tick();
        i_window_ready = 1'b0;
        chk("bp_load", 32'(o_sipo_load), 1);
        chk("bp_valid_cleared", 32'(o_window_valid), 0);
        chk("bp_idx_inc", 32'(o_window_idx), 1);
        tick();
        chk("bp_load_pulse", 32'(o_sipo_load), 0);
        chk("bp_valid2", 32'(o_window_valid), 1);
        chk("bp_idx2", 32'(o_window_idx), 1);
        chk("bp_in_ready2", 32'(o_in_ready), 1);
        chk_win("bp_window1", 16'd10);

        // Frame wrap and throughput with continuous valid/ready.
        do_reset();
        i_window_ready = 1'b1;
        w = 16'h0;
        consumes = 0;
        cyc = 0;
        first_c = 0;
        last_c = 0;
        while (consumes < 197 && cyc < 2500) begin
            i_in_valid = 1'b1;
            i_in_data = w;
            #1;
            if (o_in_ready) w = w + 16'd1;
            if (o_window_valid) begin
                chk("wrap_idx", 32'(o_window_idx), 32'(consumes % 196));
                chk("wrap_last", 32'(o_window_last), 32'(consumes % 196 == 195));
                if (consumes == 0) first_c = cyc;
                last_c = cyc;
                consumes++;
            end
            tick();
            cyc++;
        end
        i_in_valid = 1'b0;
        chk("wrap_count", 32'(consumes), 197);
        chk("wrap_period", 32'(last_c - first_c), 1960);

        // Mid-window reset discards the partial fill.
        do_reset();
        feed(16'h00A1, 5, n_acc);
        chk("mid_acc5", 32'(n_acc), 5);
        i_in_valid = 1'b1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(o_in_ready), 0);
        tick();
        i_rst = 1'b0;
        i_in_valid = 1'b0;
        chk("mid_rst_shift", 32'(o_sipo_shift_en), 0);
        chk("mid_rst_valid", 32'(o_window_valid), 0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_no_load", 32'(o_sipo_load), 0);
            tick();
        end
        feed(16'h00B1, 9, n_acc);
        chk("mid_acc9", 32'(n_acc), 9);
        cyc = 0;
        while (o_window_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("mid_valid", 32'(o_window_valid), 1);
        chk("mid_idx", 32'(o_window_idx), 0);
        chk_win("mid_window", 16'h00B1);

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
